// File: rtl/div_repsub_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
// Optional divide-by-zero error flag: DIV_REPSUB_DIVZERO_ERR_EN.
package div_repsub_pkg;

  localparam int DIV_REPSUB_WIDTH = 32;

  localparam logic [DIV_REPSUB_WIDTH-1:0] QUOT_ALL_ONES = '1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    SUB  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/div_repsub_if.sv
// Operand/result bundle for div_repsub; err exists only when
// DIV_REPSUB_DIVZERO_ERR_EN is defined.
interface div_repsub_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;

`ifdef DIV_REPSUB_DIVZERO_ERR_EN
  logic             err;

  modport master (
    output start, data_in,
    input  quotient, remainder, done, busy, err
  );

  modport slave (
    input  start, data_in,
    output quotient, remainder, done, busy, err
  );
`else
  modport master (
    output start, data_in,
    input  quotient, remainder, done, busy
  );

  modport slave (
    input  start, data_in,
    output quotient, remainder, done, busy
  );
`endif

endinterface

// File: rtl/div_repsub_datapath.sv
// Divider datapath: remainder/divisor registers, quotient counter, compare and subtract.
// DIV_REPSUB_DIVZERO_ERR_EN leaves the quotient at zero on divide-by-zero.
module div_repsub_datapath
  import div_repsub_pkg::*;
#(
  parameter int WIDTH = DIV_REPSUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld_r,
  input  logic             ld_b,
  input  logic             clr_q,
  input  logic             sub_en,
  output logic             ge,
  output logic             bz,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] quot_q;

  assign ge        = (rem_q >= div_q);
  assign bz        = (div_q == '0);
  assign quotient  = quot_q;
  assign remainder = rem_q;

  // The subtract path is guarded by ge, so the remainder never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
    end else begin
      if (ld_r) begin
        rem_q <= data_in;
      end
      if (ld_b) begin
        div_q <= data_in;
      end
      if (clr_q) begin
        quot_q <= '0;
      end
      if (sub_en && !bz && ge) begin
        rem_q  <= rem_q - div_q;
        quot_q <= quot_q + 1'b1;
      end
`ifndef DIV_REPSUB_DIVZERO_ERR_EN
      if (sub_en && bz) begin
        quot_q <= {WIDTH{QUOT_ALL_ONES[0]}};
      end
`endif
    end
  end

endmodule

// File: rtl/div_repsub.sv
// Repeated-subtraction unsigned divider: controller FSM around div_repsub_datapath.
// Define DIV_REPSUB_DIVZERO_ERR_EN to add the err output and zero quotient on x/0.
module div_repsub
  import div_repsub_pkg::*;
#(
  parameter int WIDTH = DIV_REPSUB_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  div_repsub_if.slave bus
);

  state_t state;
  state_t state_nxt;

  logic             ld_r;
  logic             ld_b;
  logic             clr_q;
  logic             sub_en;
  logic             ge;
  logic             bz;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  div_repsub_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .data_in   (bus.data_in),
    .ld_r      (ld_r),
    .ld_b      (ld_b),
    .clr_q     (clr_q),
    .sub_en    (sub_en),
    .ge        (ge),
    .bz        (bz),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operands arrive on consecutive cycles; SUB leaves as soon as the divisor no longer fits.
  always_comb begin
    state_nxt = state;
    ld_r      = 1'b0;
    ld_b      = 1'b0;
    clr_q     = 1'b0;
    sub_en    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = LDA;
        end
      end
      LDA: begin
        ld_r      = 1'b1;
        state_nxt = LDB;
      end
      LDB: begin
        ld_b      = 1'b1;
        clr_q     = 1'b1;
        state_nxt = SUB;
      end
      SUB: begin
        sub_en = 1'b1;
        if (bz || !ge) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = bus.start ? LDA : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.quotient  = quotient;
  assign bus.remainder = remainder;
  assign bus.done      = (state == DONE);
  assign bus.busy      = (state == LDA) || (state == LDB) || (state == SUB);

`ifdef DIV_REPSUB_DIVZERO_ERR_EN
  logic err_q;

  // err stays up through DONE/IDLE and clears when the next divisor is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == LDB) begin
      err_q <= 1'b0;
    end else if (state == SUB && bz) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_div_repsub.sv
// Directed self-checking bench for div_repsub; follows DIV_REPSUB_DIVZERO_ERR_EN
// to pick the divide-by-zero expectations.
module tb_div_repsub;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   lat;
  int   done_seen;

  div_repsub_if #(.WIDTH(W)) bus ();

  div_repsub #(
    .WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Entered #1 after an edge; the next edge is E0, dividend/divisor follow on the next two.
  task automatic applyStimulus(input logic [W-1:0] dividend, input logic [W-1:0] divisor,
                               input logic keep_start);
    bus.start   = 1'b1;
    bus.data_in = $urandom;
    @(posedge clk); #1;
    bus.start   = keep_start;
    bus.data_in = dividend;
    @(posedge clk); #1;
    bus.data_in = divisor;
    @(posedge clk); #1;
    bus.data_in = $urandom;
  endtask

  // Counts edges from E0 until done; lat is the edge index (relative to E0) after which done rose.
  task automatic waitDone(output int latency);
    latency = 2;
    while (bus.done !== 1'b1 && latency < 3000) begin
      @(posedge clk); #1;
      latency++;
    end
    if (bus.done !== 1'b1) begin
      $display("[TB] FAIL done_timeout observed=%0d expected=done", latency);
      errors++;
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.data_in = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_quotient", bus.quotient, 32'd0);
    checkOutput("reset_remainder", bus.remainder, 32'd0);
    checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
`ifdef DIV_REPSUB_DIVZERO_ERR_EN
    checkOutput("reset_err", {31'd0, bus.err}, 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_done", {31'd0, bus.done}, 32'd0);

    // 8020 / 9 = 891 r 1, done after E0+894
    applyStimulus(32'd8020, 32'd9, 1'b0);
    checkOutput("8020_busy_sub", {31'd0, bus.busy}, 32'd1);
    waitDone(lat);
    checkOutput("8020_latency", lat, 32'd894);
    checkOutput("8020_quotient", bus.quotient, 32'd891);
    checkOutput("8020_remainder", bus.remainder, 32'd1);
    checkOutput("8020_busy_done", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    checkOutput("8020_done_drop", {31'd0, bus.done}, 32'd0);
    checkOutput("8020_hold_q", bus.quotient, 32'd891);
    checkOutput("8020_hold_r", bus.remainder, 32'd1);

    // dividend < divisor
    applyStimulus(32'd5, 32'd7, 1'b0);
    waitDone(lat);
    checkOutput("5div7_latency", lat, 32'd3);
    checkOutput("5div7_quotient", bus.quotient, 32'd0);
    checkOutput("5div7_remainder", bus.remainder, 32'd5);

    // dividend == divisor, started straight from DONE
    applyStimulus(32'd7, 32'd7, 1'b0);
    waitDone(lat);
    checkOutput("7div7_latency", lat, 32'd4);
    checkOutput("7div7_quotient", bus.quotient, 32'd1);
    checkOutput("7div7_remainder", bus.remainder, 32'd0);
    @(posedge clk); #1;

    // divide by zero
    applyStimulus(32'd100, 32'd0, 1'b0);
    waitDone(lat);
    checkOutput("div0_latency", lat, 32'd3);
    checkOutput("div0_remainder", bus.remainder, 32'd100);
`ifdef DIV_REPSUB_DIVZERO_ERR_EN
    checkOutput("div0_quotient", bus.quotient, 32'd0);
    checkOutput("div0_err", {31'd0, bus.err}, 32'd1);
`else
    checkOutput("div0_quotient", bus.quotient, 32'hFFFF_FFFF);
`endif
    @(posedge clk); #1;

    // zero dividend
    applyStimulus(32'd0, 32'd13, 1'b0);
    waitDone(lat);
    checkOutput("0div13_latency", lat, 32'd3);
    checkOutput("0div13_quotient", bus.quotient, 32'd0);
    checkOutput("0div13_remainder", bus.remainder, 32'd0);
`ifdef DIV_REPSUB_DIVZERO_ERR_EN
    checkOutput("0div13_err", {31'd0, bus.err}, 32'd0);
`endif
    @(posedge clk); #1;

    // back-to-back with start held high: 20/6 then 9/3
    applyStimulus(32'd20, 32'd6, 1'b1);
    waitDone(lat);
    checkOutput("b2b1_latency", lat, 32'd6);
    checkOutput("b2b1_quotient", bus.quotient, 32'd3);
    checkOutput("b2b1_remainder", bus.remainder, 32'd2);
    @(posedge clk); #1;
    checkOutput("b2b_done_pulse", {31'd0, bus.done}, 32'd0);
    checkOutput("b2b_busy_lda", {31'd0, bus.busy}, 32'd1);
    checkOutput("b2b_hold_q_lda", bus.quotient, 32'd3);
    checkOutput("b2b_hold_r_lda", bus.remainder, 32'd2);
    bus.data_in = 32'd9;
    @(posedge clk); #1;
    checkOutput("b2b_hold_q_ldb", bus.quotient, 32'd3);
    bus.data_in = 32'd3;
    @(posedge clk); #1;
    bus.data_in = $urandom;
    checkOutput("b2b_clear_q", bus.quotient, 32'd0);
    waitDone(lat);
    checkOutput("b2b2_latency", lat, 32'd6);
    checkOutput("b2b2_quotient", bus.quotient, 32'd3);
    checkOutput("b2b2_remainder", bus.remainder, 32'd0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    checkOutput("b2b_idle", {31'd0, bus.busy}, 32'd0);

    // reset mid-operation: 1000 / 1, rst for the single edge E0+50
    applyStimulus(32'd1000, 32'd1, 1'b0);
    repeat (47) @(posedge clk);
    #1;
    checkOutput("midrst_busy_before", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_quotient", bus.quotient, 32'd0);
    checkOutput("midrst_remainder", bus.remainder, 32'd0);
    checkOutput("midrst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("midrst_done", {31'd0, bus.done}, 32'd0);
    done_seen = 0;
    repeat (1100) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
    end
    checkOutput("midrst_stays_idle", done_seen, 32'd0);

    // fresh division after the reset: 12 / 5 = 2 r 2
    applyStimulus(32'd12, 32'd5, 1'b0);
    waitDone(lat);
    checkOutput("12div5_latency", lat, 32'd5);
    checkOutput("12div5_quotient", bus.quotient, 32'd2);
    checkOutput("12div5_remainder", bus.remainder, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
